mux3_rr_sched: RTL and testbench
================================

# mux3_rr_sched

Round-robin scheduler that shares one 3:1 mux-based datapath among three burst requesters and drives the mux select lines. It grants one requester at a time, holds the grant for a whole burst, and emits registered, glitch-free SL0/SL1 selects. It sits directly in front of the 3-input mux cell, with the downstream sink's ACK closing the loop.

## Interface
Parameters:
- MAX_BURST, 8: beats after which a grant is forcibly released (only with MUX3_SCHED_BURST_LIMIT_EN); legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the beat counter.

Ports:
- CK  in  1  clock; all state updates on rising edge.
- RN  in  1  reset; asynchronous, active-low.
- REQ  in  3  per-requester request; bit i selects mux input A<i>.
- LAST  in  3  per-requester end-of-burst flag; sampled only for the owner on a beat.
- ACK  in  1  downstream accepts the current beat; a beat occurs when VLD && ACK.
- GNT  out  3  one-hot grant, all-zero when idle.
- SL0  out  1  mux select bit 0.
- SL1  out  1  mux select bit 1.
- VLD  out  1  a grant is active (OR of GNT).
- BEAT_CNT  out  CNT_W  beats transferred in the current burst.

## Operation
- States: IDLE (GNT=0), BUSY (exactly one GNT bit set). All outputs are registered.
- Select encoding by owner: A0 -> SL1=0,SL0=0; A1 -> SL1=0,SL0=1; A2 -> SL1=1,SL0=0. In IDLE, SL1/SL0 hold their last value and change only together with GNT.
- Round-robin pointer PTR holds the last owner. Priority order is PTR+1, PTR+2, PTR (mod 3).
- IDLE with any REQ: the highest-priority requester is granted at the next edge, state goes to BUSY, and BEAT_CNT=0.
- BUSY, beat (ACK=1): BEAT_CNT increments.
  - If LAST[owner]=1, the burst ends: PTR takes the owner index.
  - If any REQ is set in that same cycle, the next owner is arbitrated with the updated PTR and granted at the next edge with no idle gap. This can re-grant the same requester only if it is the sole requester.
  - Otherwise the next state is IDLE.
- BUSY, REQ[owner]=0 with no beat: abort. Release and rearbitrate exactly as on burst end.
- BUSY, no ACK and REQ[owner]=1: hold all outputs.
- REQ or LAST of non-owners never affects the current grant.
- BEAT_CNT saturates at 2^CNT_W-1 and clears on every new grant and on entry to IDLE.

## Timing
- Reset (RN low, asynchronous):
  - GNT=3'b000, VLD=0, SL0=0, SL1=0, BEAT_CNT=0, state=IDLE.
  - PTR=2, so A0 has first priority.
- Grant latency: 1 cycle from REQ sampled high in IDLE to GNT/VLD/SL valid.
- Release-to-next-grant: 0 idle cycles. A new GNT appears at the edge after the final beat.
- SL0/SL1 update at the same edge as GNT. They never take the value SL1=1,SL0=1, and never pass through an intermediate encoding.
- Reset deasserted mid-burst: the burst is lost and the block restarts in IDLE with PTR=2. Deassertion is synchronized externally.
- Simultaneous LAST on a beat and owner REQ drop: treated as a normal burst end.

## Configuration
- MUX3_SCHED_BURST_LIMIT_EN defined:
  - A beat with BEAT_CNT==MAX_BURST-1 ends the burst as if LAST were set, so PTR advances and other requesters get service.
- Not defined:
  - Bursts end only on LAST or an abort, and MAX_BURST is unused.
  - BEAT_CNT still counts and saturates.

## Test plan
- Reset then REQ=3'b111, ACK=1, LAST=3'b111: grants GNT=001, 010, 100, 001 on consecutive cycles. Selects go (SL1,SL0)=00, 01, 10, 00.
- REQ=3'b010 alone, ACK=0 for 5 cycles, then ACK=1 with LAST[1]=1: GNT=010 holds with BEAT_CNT=0. The grant is released one cycle after the beat, then VLD=0.
- Owner A2 drops REQ mid-burst with REQ[0]=1: abort, and GNT=001 at the next edge with BEAT_CNT=0.
- Burst limit with macro defined and MAX_BURST=4: REQ=3'b011, LAST=0, ACK=1.
  - A0 is released after 4 beats, then A1 is granted.
  - Without the macro, A0 holds indefinitely and BEAT_CNT saturates at 15.
- Assert RN low mid-burst (GNT=010, BEAT_CNT=3): outputs clear immediately without a clock. After release with REQ=3'b111, A0 is granted first.
- Randomized REQ/LAST/ACK for 10k cycles, checked against assertions:
  - GNT is one-hot or zero.
  - SL encoding matches GNT.
  - No requester waits more than 2 full bursts while REQ is held.

Source files
------------

// File: rtl/mux3_rr_sched.sv
// Round-robin scheduler for three burst requesters sharing a 3:1 mux; drives registered SL1/SL0.
// Optional forced release after MAX_BURST beats when MUX3_SCHED_BURST_LIMIT_EN is defined.
module mux3_rr_sched #(
   parameter int unsigned MAX_BURST = 8,
   parameter int unsigned CNT_W     = 4
) (
   input  logic             CK,
   input  logic             RN,
   input  logic [2:0]       REQ,
   input  logic [2:0]       LAST,
   input  logic             ACK,
   output logic [2:0]       GNT,
   output logic             SL0,
   output logic             SL1,
   output logic             VLD,
   output logic [CNT_W-1:0] BEAT_CNT
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

`ifdef MUX3_SCHED_BURST_LIMIT_EN
   localparam logic LIMIT_EN = 1'b1;
`else
   localparam logic LIMIT_EN = 1'b0;
`endif
   localparam logic [CNT_W-1:0] CNT_SAT = '1;
   localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_BURST - 1);

   state_t           r_state, w_state_nxt;
   logic [2:0]       r_gnt, w_gnt_nxt;
   logic             r_sl0, r_sl1, w_sl0_nxt, w_sl1_nxt;
   logic             r_vld;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [1:0]       r_ptr, w_ptr_nxt, w_own, w_arb_ptr;
   logic [2:0]       w_arb;
   logic             w_limit, w_end, w_abort;

   // Priority order is ptr+1, ptr+2, ptr (mod 3).
   function automatic logic [2:0] f_arb(input logic [2:0] req, input logic [1:0] ptr);
      logic [2:0] g;
      g = '0;
      case (ptr)
         2'd0: begin
            if (req[1])      g = 3'b010;
            else if (req[2]) g = 3'b100;
            else if (req[0]) g = 3'b001;
         end
         2'd1: begin
            if (req[2])      g = 3'b100;
            else if (req[0]) g = 3'b001;
            else if (req[1]) g = 3'b010;
         end
         default: begin
            if (req[0])      g = 3'b001;
            else if (req[1]) g = 3'b010;
            else if (req[2]) g = 3'b100;
         end
      endcase
      return g;
   endfunction

   always_comb begin
      w_own     = r_gnt[2] ? 2'd2 : (r_gnt[1] ? 2'd1 : 2'd0);
      w_limit   = LIMIT_EN & (r_cnt == LIMIT);
      w_end     = ACK & (LAST[w_own] | w_limit);
      w_abort   = ~ACK & ~REQ[w_own];
      w_arb_ptr = (r_state == S_BUSY) ? w_own : r_ptr;
      w_arb     = f_arb(REQ, w_arb_ptr);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_sl0_nxt   = r_sl0;
      w_sl1_nxt   = r_sl1;
      w_cnt_nxt   = r_cnt;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         S_IDLE: begin
            if (|REQ) begin
               w_state_nxt = S_BUSY;
               w_gnt_nxt   = w_arb;
               w_sl0_nxt   = w_arb[1];
               w_sl1_nxt   = w_arb[2];
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            // Burst end and abort share the release path; arbitration already uses the owner as PTR.
            if (w_end || w_abort) begin
               w_ptr_nxt = w_own;
               w_cnt_nxt = '0;
               if (|REQ) begin
                  w_gnt_nxt = w_arb;
                  w_sl0_nxt = w_arb[1];
                  w_sl1_nxt = w_arb[2];
               end else begin
                  w_state_nxt = S_IDLE;
                  w_gnt_nxt   = '0;
               end
            end else if (ACK && (r_cnt != CNT_SAT)) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         r_state <= S_IDLE;
         r_gnt   <= '0;
         r_sl0   <= 1'b0;
         r_sl1   <= 1'b0;
         r_vld   <= 1'b0;
         r_cnt   <= '0;
         r_ptr   <= 2'd2;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_sl0   <= w_sl0_nxt;
         r_sl1   <= w_sl1_nxt;
         r_vld   <= |w_gnt_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   assign GNT      = r_gnt;
   assign SL0      = r_sl0;
   assign SL1      = r_sl1;
   assign VLD      = r_vld;
   assign BEAT_CNT = r_cnt;

endmodule

// File: tb/tb_mux3_rr_sched.sv
// Bench for mux3_rr_sched: directed scenarios plus randomized traffic against an owner/pointer model.
module tb_mux3_rr_sched;

   localparam int MAXB = 4;
   localparam int SAT  = 15;
`ifdef MUX3_SCHED_BURST_LIMIT_EN
   localparam bit LIM = 1'b1;
`else
   localparam bit LIM = 1'b0;
`endif

   logic       CK, RN, ACK;
   logic [2:0] REQ, LAST;
   logic [2:0] GNT;
   logic       SL0, SL1, VLD;
   logic [3:0] BEAT_CNT;

   int checks = 0;
   int errors = 0;

   // model state
   int m_own, m_ptr, m_cnt;
   bit m_sl0, m_sl1;
   int wt[3];
   logic [2:0] prev_gnt;

   mux3_rr_sched #(.MAX_BURST(MAXB), .CNT_W(4)) dut (
      .CK(CK), .RN(RN), .REQ(REQ), .LAST(LAST), .ACK(ACK),
      .GNT(GNT), .SL0(SL0), .SL1(SL1), .VLD(VLD), .BEAT_CNT(BEAT_CNT)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int arb(input logic [2:0] req, input int ptr);
      for (int k = 1; k <= 3; k++) begin
         if (req[(ptr + k) % 3]) return (ptr + k) % 3;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_own = -1; m_ptr = 2; m_cnt = 0; m_sl0 = 0; m_sl1 = 0;
      for (int i = 0; i < 3; i++) wt[i] = 0;
      prev_gnt = '0;
   endtask

   task automatic take(input int o);
      m_own = o; m_cnt = 0;
      if (o >= 0) begin
         m_sl0 = (o == 1);
         m_sl1 = (o == 2);
      end
   endtask

   task automatic model_edge(input logic [2:0] req, input logic [2:0] last, input logic ack);
      bit endb, abrt;
      if (m_own < 0) begin
         if (req != 0) take(arb(req, m_ptr));
      end else begin
         endb = ack && (last[m_own] || (LIM && m_cnt == MAXB - 1));
         abrt = !ack && !req[m_own];
         if (ack && m_cnt < SAT) m_cnt++;
         if (endb || abrt) begin
            m_ptr = m_own;
            take(arb(req, m_ptr));
         end
      end
   endtask

   task automatic model_check(input string tag);
      logic [2:0] eg;
      eg = (m_own < 0) ? 3'b000 : (3'b001 << m_own);
      chk({tag, ".gnt"}, 8'(GNT), 8'(eg));
      chk({tag, ".vld"}, 8'(VLD), 8'(m_own >= 0));
      chk({tag, ".sl0"}, 8'(SL0), 8'(m_sl0));
      chk({tag, ".sl1"}, 8'(SL1), 8'(m_sl1));
      chk({tag, ".cnt"}, 8'(BEAT_CNT), 8'(m_cnt));
   endtask

   // One clock: advance model on the edge DUT sees, then compare 1 time unit later.
   task automatic step(input string tag);
      logic [2:0] rq, ls;
      logic       ak;
      bit         newg;
      rq = REQ; ls = LAST; ak = ACK;
      @(posedge CK);
      if (RN) model_edge(rq, ls, ak);
      #1;
      model_check(tag);
      newg = (GNT != 3'b000) && (GNT != prev_gnt);
      for (int i = 0; i < 3; i++) begin
         if (rq[i] && !GNT[i]) begin
            if (newg) begin
               wt[i]++;
               checks++;
               assert (wt[i] <= 2) else begin
                  errors++;
                  $error("FAIL fair%0d observed=%0d expected<=2", i, wt[i]);
               end
            end
         end else begin
            wt[i] = 0;
         end
      end
      prev_gnt = GNT;
   endtask

   task automatic do_reset();
      #2 RN = 1'b0;
      #1;
      model_reset();
      @(posedge CK);
      #1 RN = 1'b1;
   endtask

   initial begin
      RN = 1'b0; REQ = '0; LAST = '0; ACK = 1'b0;
      model_reset();
      repeat (2) @(posedge CK);
      #1;
      model_check("rst");
      chk("rst.gnt0", 8'(GNT), 8'h00);
      RN = 1'b1;

      // Full round-robin rotation, one beat per burst
      REQ = 3'b111; ACK = 1'b1; LAST = 3'b111;
      step("rr1"); chk("rr1.g", 8'(GNT), 8'h01); chk("rr1.s", 8'({SL1, SL0}), 8'h0);
      step("rr2"); chk("rr2.g", 8'(GNT), 8'h02); chk("rr2.s", 8'({SL1, SL0}), 8'h1);
      step("rr3"); chk("rr3.g", 8'(GNT), 8'h04); chk("rr3.s", 8'({SL1, SL0}), 8'h2);
      step("rr4"); chk("rr4.g", 8'(GNT), 8'h01); chk("rr4.s", 8'({SL1, SL0}), 8'h0);

      // Sole requester A1 stalled, then final beat with REQ dropped
      REQ = 3'b010; ACK = 1'b0; LAST = 3'b000;
      step("h0");
      for (int i = 0; i < 5; i++) step("hold");
      chk("hold.g", 8'(GNT), 8'h02); chk("hold.c", 8'(BEAT_CNT), 8'h0);
      REQ = 3'b000; ACK = 1'b1; LAST = 3'b010;
      step("rel");
      chk("rel.v", 8'(VLD), 8'h0); chk("rel.sl0", 8'(SL0), 8'h1);
      ACK = 1'b0; LAST = 3'b000;
      step("idle");

      // Owner A2 aborts while A0 waits
      REQ = 3'b100;
      step("a2");
      chk("a2.g", 8'(GNT), 8'h04);
      REQ = 3'b001;
      step("abort");
      chk("abort.g", 8'(GNT), 8'h01); chk("abort.c", 8'(BEAT_CNT), 8'h0);

      // Long bursts: forced release with the limit, saturation without
      do_reset();
      REQ = 3'b011; LAST = 3'b000; ACK = 1'b1;
      step("lim0");
      for (int i = 0; i < 4; i++) step("lim");
      chk("lim.g", 8'(GNT), LIM ? 8'h02 : 8'h01);
      for (int i = 0; i < 16; i++) step("sat");
      if (!LIM) chk("sat.c", 8'(BEAT_CNT), 8'(SAT));

      // Asynchronous reset mid-burst
      do_reset();
      REQ = 3'b010; ACK = 1'b1;
      for (int i = 0; i < 4; i++) step("mid");
      chk("mid.c", 8'(BEAT_CNT), 8'h3);
      #2 RN = 1'b0;
      #1;
      model_reset();
      chk("arst.g", 8'(GNT), 8'h00); chk("arst.v", 8'(VLD), 8'h0); chk("arst.c", 8'(BEAT_CNT), 8'h0);
      model_check("arst");
      REQ = 3'b111;
      #1 RN = 1'b1;
      step("post");
      chk("post.g", 8'(GNT), 8'h01);

      // Randomized traffic with sticky requests
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < 3; i++) begin
            if ($urandom_range(7) == 0) REQ[i] = ~REQ[i];
            LAST[i] = ($urandom_range(3) == 0);
         end
         ACK = ($urandom_range(9) < 7);
         step("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
